decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised ARM-style decode stage. Accepts one fetched instruction per cycle over a valid/ready handshake, evaluates its condition against NZCV flags (with same-cycle flag bypass), classifies it into a UOP class, reads and forwards operands from a configurable number of result buses, and presents a registered decode packet to the execute stage. It sits between fetch and execute and replaces the earlier purely combinational decoder.

## Interface
- `DATA_W`, 32: operand and result width.
- `NUM_FWD`, 2: number of forwarding sources; index 0 has the highest priority (youngest).
- `CNT_W`, 16: width of the statistics counters.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_valid_i` in 1 / `instr_ready_o` out 1 / `instr_i` in 32: fetch handshake and instruction word.
- `flush_i` in 1: squash the held packet and any instruction offered this cycle.
- `flags_we_i` in 1 / `flags_i` in 4: NZCV write from execute.
- `rr1_i_o`..`rr4_i_o` out 4 each: register-file read addresses, combinational from `instr_i`.
- `rr1_i`..`rr4_i` in DATA_W each: read data, same cycle.
- `fwd_valid_i` in NUM_FWD / `fwd_dest_i` in 4*NUM_FWD / `fwd_data_i` in DATA_W*NUM_FWD: forwarding buses.
- `d_valid_o` out 1 / `d_ready_i` in 1: handshake to execute.
- `d_class_o` out 4: UOP class. `d_exec_o` out 1: condition passed.
- `d_opcode_o` out 4, `d_type_o` out 3, `d_shift_o` out 8 (instr[11:4]), `d_dest_o` out 4, `d_dest_hi_o` out 4.
- `d_write_dest_o`, `d_write_cpsr_o` out 1 each.
- `d_a_o`, `d_b_o`, `d_c_o`, `d_d_o` out DATA_W each: operands.
- `dec_count_o`, `squash_count_o` out CNT_W each.

## Operation
- Class decode on `instr_i`, in priority order:
  - instr[27:0] equal to the NOP pattern gives class 0, exec=0, no writes.
  - instr[27:25]=101 gives BRANCH (1); `d_b_o` = sign-extended imm24<<2.
  - !instr[25] && instr[7] && instr[4] && instr[27:24]=0000 gives MUL (3); see Configuration.
  - instr[27:26]=00 gives INTEGER (2).
  - instr[27:26]=01 gives LOAD (4) if instr[20], else STORE (5).
  - Anything else gives class 0, exec=0.
- Data processing: a=Rn[19:16], dest=[15:12], opcode=[24:21].
  - If instr[25]: b = imm8 rotated right by 2*instr[11:8].
  - Otherwise: b = Rm[3:0], and the shift field is passed in `d_shift_o`.
  - TST/TEQ/CMP/CMN (1000–1011): write_dest=0, write_cpsr=1.
  - Other opcodes: write_dest=1, write_cpsr=instr[20].
- Load/store: a=Rn, b=imm12 or Rm, d=Rd (store data), dest=Rd, write_dest=L.
- Multiply: a=Rm[3:0], b=Rs[11:8], c=Rn[15:12], dest=[19:16], type=[23:21], write_cpsr=instr[20].
  - Long forms (instr[23]): dest_hi=[19:16], dest lo=[15:12], d=RdLo.
- Forwarding: each operand takes `fwd_data_i` of the lowest index k with `fwd_valid_i[k]` && dest match, otherwise the register-file data.
- Condition evaluation uses effective flags = `flags_we_i ? flags_i : flags_q`.
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&&!Z, LS !C||Z, GE N==V, LT N!=V, GT !Z&&N==V, LE Z||N!=V.
  - AL 1; 1111 gives 0.
- `flags_q` loads `flags_i` whenever `flags_we_i` is high.
- Counters:
  - `dec_count_o` increments per accepted instruction.
  - `squash_count_o` increments per accepted packet with exec=0, plus per flush that kills a valid held packet.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset state: all outputs 0, `flags_q`=0, counters 0, `instr_ready_o`=1.
- Accept when `instr_valid_i && instr_ready_o`. The packet is visible on `d_*` the next cycle (1-cycle latency).
- `instr_ready_o` = !`d_valid_o` || `d_ready_i`. Back-to-back accepts sustain 1 instruction per cycle.
- While `d_valid_o` && !`d_ready_i`, all `d_*` outputs hold stable.
- Operands are not re-forwarded while held.
- `flush_i`: `d_valid_o` goes to 0 next cycle, and the instruction offered that cycle is dropped (not counted as decoded). Flush wins over a simultaneous accept.
- A flag write in the accept cycle is bypassed into the condition evaluation of that instruction.
- When `rst_n` is asserted mid-stream, state clears immediately and the held packet is lost.

## Configuration
- `DECODE_MUL_EN` defined: multiply and multiply-long decode as class 3 as above.
- Undefined: the multiply pattern gives class 0, exec=0, no writes. The multiply operand muxing and `d_c_o`/`d_dest_hi_o` logic are removed, and those outputs are tied to 0.

## Structure
- Shared package `limb_pkg`: UOP class constants (BRANCH=1 … FP=6), condition code constants, the NOP pattern, and the NZCV bit indices.
- Sub-module `cond_eval`: purely combinational; inputs cond[3:0] and nzcv[3:0]; output pass.
- Operand forwarding: a generate loop inside `decode_stage`.

## Test plan
- Flags NZCV=0100, AL `ADD r1,r2,#0xFF` with r2=5 → next cycle class 2, a=5, b=0xFF, dest=1, write_dest=1, exec=1.
- `CMP` with cond GT while `flags_we_i`=1 and `flags_i`=0000 in the same cycle → exec=1, write_cpsr=1, write_dest=0. Repeat with flags 0100 → exec=0, squash_count +1.
- Rn=r3, fwd0 (dest 3, 0xAAAA) and fwd1 (dest 3, 0xBBBB) both valid → a=0xAAAA.
- Immediate imm8=0x01 with rotate 4 → b=0x01000000.
- `d_ready_i`=0 for 3 cycles while the next instruction is offered → outputs stable and `instr_ready_o`=0; release → next packet one cycle later. Flush during the stall → `d_valid_o`=0 and the offered instruction is dropped.
- `MUL r4,r5,r6` with `DECODE_MUL_EN` defined → class 3, dest=4. Without the macro → class 0, exec=0.

Source files
------------

// File: rtl/limb_pkg.sv
// limb_pkg: shared UOP class codes, ARM condition codes, the NOP pattern and NZCV bit positions.
package limb_pkg;

  localparam logic [3:0] UOP_NONE    = 4'd0;
  localparam logic [3:0] UOP_BRANCH  = 4'd1;
  localparam logic [3:0] UOP_INTEGER = 4'd2;
  localparam logic [3:0] UOP_MUL     = 4'd3;
  localparam logic [3:0] UOP_LOAD    = 4'd4;
  localparam logic [3:0] UOP_STORE   = 4'd5;
  localparam logic [3:0] UOP_FP      = 4'd6;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // MOV r0, r0 with the condition field stripped
  localparam logic [27:0] NOP_PATTERN = 28'h1A0_0000;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-code test against an NZCV nibble.
module cond_eval
  import limb_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv[NZCV_N];
    z = nzcv[NZCV_Z];
    c = nzcv[NZCV_C];
    v = nzcv[NZCV_V];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered ARM-style decode with flag bypass, operand forwarding and statistics.
// Define DECODE_MUL_EN to decode multiply / multiply-long as class 3; otherwise they decode as class 0.
module decode_stage
  import limb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [31:0]            instr_i,
  input  logic                   flush_i,
  input  logic                   flags_we_i,
  input  logic [3:0]             flags_i,
  output logic [3:0]             rr1_i_o,
  output logic [3:0]             rr2_i_o,
  output logic [3:0]             rr3_i_o,
  output logic [3:0]             rr4_i_o,
  input  logic [DATA_W-1:0]      rr1_i,
  input  logic [DATA_W-1:0]      rr2_i,
  input  logic [DATA_W-1:0]      rr3_i,
  input  logic [DATA_W-1:0]      rr4_i,
  input  logic [NUM_FWD-1:0]     fwd_valid_i,
  input  logic [4*NUM_FWD-1:0]   fwd_dest_i,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_data_i,
  output logic                   d_valid_o,
  input  logic                   d_ready_i,
  output logic [3:0]             d_class_o,
  output logic                   d_exec_o,
  output logic [3:0]             d_opcode_o,
  output logic [2:0]             d_type_o,
  output logic [7:0]             d_shift_o,
  output logic [3:0]             d_dest_o,
  output logic [3:0]             d_dest_hi_o,
  output logic                   d_write_dest_o,
  output logic                   d_write_cpsr_o,
  output logic [DATA_W-1:0]      d_a_o,
  output logic [DATA_W-1:0]      d_b_o,
  output logic [DATA_W-1:0]      d_c_o,
  output logic [DATA_W-1:0]      d_d_o,
  output logic [CNT_W-1:0]       dec_count_o,
  output logic [CNT_W-1:0]       squash_count_o
);

  function automatic logic [31:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [63:0] dbl;
    dbl = {24'd0, imm8, 24'd0, imm8} >> {rot, 1'b0};
    return dbl[31:0];
  endfunction

  logic [3:0]        flags_q, eff_flags;
  logic              cond_pass, accept;
  logic              is_nop, is_branch, is_mul_pat, is_dp, is_ls;
  logic [3:0]        rd_addr [4];
  logic [DATA_W-1:0] rd_data [4];
  logic [DATA_W-1:0] op_fwd  [4];
  logic signed [25:0] br_off;

  logic [3:0]        cls_n, opcode_n, dest_n;
  logic [2:0]        type_n;
  logic [7:0]        shift_n;
  logic              wr_dest_n, wr_cpsr_n, exec_n;
  logic [DATA_W-1:0] a_n, b_n, d_n;

  logic              vld_p1, exec_p1, wr_dest_p1, wr_cpsr_p1;
  logic [3:0]        cls_p1, opcode_p1, dest_p1;
  logic [2:0]        type_p1;
  logic [7:0]        shift_p1;
  logic [DATA_W-1:0] a_p1, b_p1, d_p1;
  logic [CNT_W-1:0]  dec_cnt, squash_cnt;

  assign eff_flags = flags_we_i ? flags_i : flags_q;

  cond_eval u_cond_eval (
    .cond (instr_i[31:28]),
    .nzcv (eff_flags),
    .pass (cond_pass)
  );

  assign is_nop     = (instr_i[27:0] == NOP_PATTERN);
  assign is_branch  = !is_nop && (instr_i[27:25] == 3'b101);
  assign is_mul_pat = !is_nop && !is_branch && !instr_i[25] && instr_i[7] && instr_i[4]
                      && (instr_i[27:24] == 4'b0000);
  assign is_dp      = !is_nop && !is_branch && !is_mul_pat && (instr_i[27:26] == 2'b00);
  assign is_ls      = !is_nop && (instr_i[27:26] == 2'b01);
  assign br_off     = {instr_i[23:0], 2'b00};

`ifdef DECODE_MUL_EN
  assign rr1_i_o = is_mul_pat ? instr_i[3:0]  : instr_i[19:16];
  assign rr2_i_o = is_mul_pat ? instr_i[11:8] : instr_i[3:0];
  assign rr3_i_o = is_mul_pat ? instr_i[15:12] : 4'd0;
`else
  assign rr1_i_o = instr_i[19:16];
  assign rr2_i_o = instr_i[3:0];
  assign rr3_i_o = 4'd0;
`endif
  assign rr4_i_o = instr_i[15:12];

  assign rd_addr[0] = rr1_i_o;
  assign rd_addr[1] = rr2_i_o;
  assign rd_addr[2] = rr3_i_o;
  assign rd_addr[3] = rr4_i_o;
  assign rd_data[0] = rr1_i;
  assign rd_data[1] = rr2_i;
  assign rd_data[2] = rr3_i;
  assign rd_data[3] = rr4_i;

  // Scan from oldest to youngest so the lowest matching index wins.
  for (genvar j = 0; j < 4; j++) begin : g_fwd
    logic [DATA_W-1:0] fwd_val;
    always_comb begin
      fwd_val = rd_data[j];
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_valid_i[k] && (fwd_dest_i[4*k +: 4] == rd_addr[j]))
          fwd_val = fwd_data_i[DATA_W*k +: DATA_W];
      end
    end
    assign op_fwd[j] = fwd_val;
  end

  always_comb begin
    cls_n     = UOP_NONE;
    opcode_n  = 4'd0;
    type_n    = 3'd0;
    shift_n   = 8'd0;
    dest_n    = 4'd0;
    wr_dest_n = 1'b0;
    wr_cpsr_n = 1'b0;
    a_n       = '0;
    b_n       = '0;
    d_n       = '0;
    if (is_branch) begin
      cls_n = UOP_BRANCH;
      b_n   = DATA_W'(br_off);
    end
`ifdef DECODE_MUL_EN
    else if (is_mul_pat) begin
      cls_n     = UOP_MUL;
      type_n    = instr_i[23:21];
      a_n       = op_fwd[0];
      b_n       = op_fwd[1];
      wr_dest_n = 1'b1;
      wr_cpsr_n = instr_i[20];
      dest_n    = instr_i[23] ? instr_i[15:12] : instr_i[19:16];
      d_n       = instr_i[23] ? op_fwd[3] : '0;
    end
`endif
    else if (is_dp) begin
      cls_n    = UOP_INTEGER;
      opcode_n = instr_i[24:21];
      a_n      = op_fwd[0];
      dest_n   = instr_i[15:12];
      b_n      = instr_i[25] ? DATA_W'(rot_imm(instr_i[7:0], instr_i[11:8])) : op_fwd[1];
      shift_n  = instr_i[25] ? 8'd0 : instr_i[11:4];
      // TST/TEQ/CMP/CMN only update flags
      wr_dest_n = (instr_i[24:23] != 2'b10);
      wr_cpsr_n = (instr_i[24:23] == 2'b10) || instr_i[20];
    end else if (is_ls) begin
      cls_n     = instr_i[20] ? UOP_LOAD : UOP_STORE;
      a_n       = op_fwd[0];
      b_n       = instr_i[25] ? op_fwd[1] : DATA_W'(instr_i[11:0]);
      shift_n   = instr_i[25] ? instr_i[11:4] : 8'd0;
      d_n       = op_fwd[3];
      dest_n    = instr_i[15:12];
      wr_dest_n = instr_i[20];
    end
  end

  assign exec_n        = (cls_n != UOP_NONE) && cond_pass;
  assign instr_ready_o = !vld_p1 || d_ready_i;
  assign accept        = instr_valid_i && instr_ready_o && !flush_i;

  // Stage p1: registered decode packet, held while execute stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= 4'd0;
      vld_p1     <= 1'b0;
      dec_cnt    <= '0;
      squash_cnt <= '0;
      exec_p1    <= 1'b0;
      wr_dest_p1 <= 1'b0;
      wr_cpsr_p1 <= 1'b0;
      cls_p1     <= 4'd0;
      opcode_p1  <= 4'd0;
      dest_p1    <= 4'd0;
      type_p1    <= 3'd0;
      shift_p1   <= 8'd0;
      a_p1       <= '0;
      b_p1       <= '0;
      d_p1       <= '0;
    end else begin
      if (flags_we_i) flags_q <= flags_i;
      if (flush_i) begin
        vld_p1 <= 1'b0;
        if (vld_p1) squash_cnt <= squash_cnt + CNT_W'(1);
      end else if (accept) begin
        vld_p1     <= 1'b1;
        dec_cnt    <= dec_cnt + CNT_W'(1);
        if (!exec_n) squash_cnt <= squash_cnt + CNT_W'(1);
        exec_p1    <= exec_n;
        wr_dest_p1 <= wr_dest_n;
        wr_cpsr_p1 <= wr_cpsr_n;
        cls_p1     <= cls_n;
        opcode_p1  <= opcode_n;
        dest_p1    <= dest_n;
        type_p1    <= type_n;
        shift_p1   <= shift_n;
        a_p1       <= a_n;
        b_p1       <= b_n;
        d_p1       <= d_n;
      end else if (d_ready_i) begin
        vld_p1 <= 1'b0;
      end
    end
  end

`ifdef DECODE_MUL_EN
  logic [DATA_W-1:0] c_p1;
  logic [3:0]        dest_hi_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_p1       <= '0;
      dest_hi_p1 <= 4'd0;
    end else if (accept) begin
      c_p1       <= is_mul_pat ? op_fwd[2] : '0;
      dest_hi_p1 <= (is_mul_pat && instr_i[23]) ? instr_i[19:16] : 4'd0;
    end
  end

  assign d_c_o       = c_p1;
  assign d_dest_hi_o = dest_hi_p1;
`else
  logic unused_mul;
  assign unused_mul  = ^op_fwd[2];
  assign d_c_o       = '0;
  assign d_dest_hi_o = 4'd0;
`endif

  assign d_valid_o      = vld_p1;
  assign d_class_o      = cls_p1;
  assign d_exec_o       = exec_p1;
  assign d_opcode_o     = opcode_p1;
  assign d_type_o       = type_p1;
  assign d_shift_o      = shift_p1;
  assign d_dest_o       = dest_p1;
  assign d_write_dest_o = wr_dest_p1;
  assign d_write_cpsr_o = wr_cpsr_p1;
  assign d_a_o          = a_p1;
  assign d_b_o          = b_p1;
  assign d_d_o          = d_p1;
  assign dec_count_o    = dec_cnt;
  assign squash_count_o = squash_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage (honours DECODE_MUL_EN if defined).
module tb_decode_stage;

  localparam int DATA_W  = 32;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_valid_i = 1'b0;
  logic instr_ready_o;
  logic [31:0] instr_i = 32'd0;
  logic flush_i = 1'b0;
  logic flags_we_i = 1'b0;
  logic [3:0] flags_i = 4'd0;
  logic [3:0] rr1_i_o, rr2_i_o, rr3_i_o, rr4_i_o;
  logic [DATA_W-1:0] rr1_i, rr2_i, rr3_i, rr4_i;
  logic [NUM_FWD-1:0] fwd_valid_i = '0;
  logic [4*NUM_FWD-1:0] fwd_dest_i = '0;
  logic [DATA_W*NUM_FWD-1:0] fwd_data_i = '0;
  logic d_valid_o;
  logic d_ready_i = 1'b1;
  logic [3:0] d_class_o, d_opcode_o, d_dest_o, d_dest_hi_o;
  logic d_exec_o, d_write_dest_o, d_write_cpsr_o;
  logic [2:0] d_type_o;
  logic [7:0] d_shift_o;
  logic [DATA_W-1:0] d_a_o, d_b_o, d_c_o, d_d_o;
  logic [CNT_W-1:0] dec_count_o, squash_count_o;

  logic [31:0] rf [16];
  int nvec = 0;
  int nfail = 0;
  int exp_dec = 0;
  int exp_sq = 0;

  always #5 clk = ~clk;

  assign rr1_i = rf[rr1_i_o];
  assign rr2_i = rf[rr2_i_o];
  assign rr3_i = rf[rr3_i_o];
  assign rr4_i = rf[rr4_i_o];

  decode_stage #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
    .flush_i(flush_i), .flags_we_i(flags_we_i), .flags_i(flags_i),
    .rr1_i_o(rr1_i_o), .rr2_i_o(rr2_i_o), .rr3_i_o(rr3_i_o), .rr4_i_o(rr4_i_o),
    .rr1_i(rr1_i), .rr2_i(rr2_i), .rr3_i(rr3_i), .rr4_i(rr4_i),
    .fwd_valid_i(fwd_valid_i), .fwd_dest_i(fwd_dest_i), .fwd_data_i(fwd_data_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
    .d_class_o(d_class_o), .d_exec_o(d_exec_o), .d_opcode_o(d_opcode_o),
    .d_type_o(d_type_o), .d_shift_o(d_shift_o), .d_dest_o(d_dest_o),
    .d_dest_hi_o(d_dest_hi_o), .d_write_dest_o(d_write_dest_o),
    .d_write_cpsr_o(d_write_cpsr_o),
    .d_a_o(d_a_o), .d_b_o(d_b_o), .d_c_o(d_c_o), .d_d_o(d_d_o),
    .dec_count_o(dec_count_o), .squash_count_o(squash_count_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    instr_i = ins;
    instr_valid_i = 1'b1;
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    nvec++; if (d_valid_o !== 1'b0) begin nfail++; $display("FAIL reset_valid got %0h want 0", d_valid_o); end
    nvec++; if (instr_ready_o !== 1'b1) begin nfail++; $display("FAIL reset_ready got %0h want 1", instr_ready_o); end
    nvec++; if (d_class_o !== 4'd0) begin nfail++; $display("FAIL reset_class got %0h want 0", d_class_o); end
    nvec++; if (d_a_o !== 32'd0) begin nfail++; $display("FAIL reset_a got %0h want 0", d_a_o); end
    nvec++; if (dec_count_o !== 16'd0) begin nfail++; $display("FAIL reset_dec got %0d want 0", dec_count_o); end
    nvec++; if (squash_count_o !== 16'd0) begin nfail++; $display("FAIL reset_sq got %0d want 0", squash_count_o); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    flags_we_i = 1'b1; flags_i = 4'b0100;
    tick();
    flags_we_i = 1'b0;
    instr_i = 32'hE28210FF;
    #1;
    nvec++; if (rr1_i_o !== 4'd2) begin nfail++; $display("FAIL add_rr1 got %0h want 2", rr1_i_o); end
    nvec++; if (rr4_i_o !== 4'd1) begin nfail++; $display("FAIL add_rr4 got %0h want 1", rr4_i_o); end
    send(32'hE28210FF); exp_dec++;
    nvec++; if (d_valid_o !== 1'b1) begin nfail++; $display("FAIL add_valid got %0h want 1", d_valid_o); end
    nvec++; if (d_class_o !== 4'd2) begin nfail++; $display("FAIL add_class got %0h want 2", d_class_o); end
    nvec++; if (d_exec_o !== 1'b1) begin nfail++; $display("FAIL add_exec got %0h want 1", d_exec_o); end
    nvec++; if (d_a_o !== 32'd5) begin nfail++; $display("FAIL add_a got %0h want 5", d_a_o); end
    nvec++; if (d_b_o !== 32'hFF) begin nfail++; $display("FAIL add_b got %0h want ff", d_b_o); end
    nvec++; if (d_dest_o !== 4'd1) begin nfail++; $display("FAIL add_dest got %0h want 1", d_dest_o); end
    nvec++; if (d_opcode_o !== 4'd4) begin nfail++; $display("FAIL add_opcode got %0h want 4", d_opcode_o); end
    nvec++; if ({d_write_dest_o, d_write_cpsr_o} !== 2'b10) begin nfail++; $display("FAIL add_wr got %b want 10", {d_write_dest_o, d_write_cpsr_o}); end
    nvec++; if (dec_count_o !== 16'(exp_dec)) begin nfail++; $display("FAIL add_dec got %0d want %0d", dec_count_o, exp_dec); end
  endtask

  task automatic test_cond();
    flags_we_i = 1'b1; flags_i = 4'b0000;
    send(32'hC3510000); exp_dec++;
    flags_we_i = 1'b0;
    nvec++; if (d_exec_o !== 1'b1) begin nfail++; $display("FAIL cmp_gt_exec got %0h want 1", d_exec_o); end
    nvec++; if ({d_write_dest_o, d_write_cpsr_o} !== 2'b01) begin nfail++; $display("FAIL cmp_wr got %b want 01", {d_write_dest_o, d_write_cpsr_o}); end
    nvec++; if (d_opcode_o !== 4'hA) begin nfail++; $display("FAIL cmp_opcode got %0h want a", d_opcode_o); end
    flags_we_i = 1'b1; flags_i = 4'b0100;
    send(32'hC3510000); exp_dec++; exp_sq++;
    flags_we_i = 1'b0;
    nvec++; if (d_exec_o !== 1'b0) begin nfail++; $display("FAIL cmp_z_exec got %0h want 0", d_exec_o); end
    nvec++; if (squash_count_o !== 16'(exp_sq)) begin nfail++; $display("FAIL cmp_sq got %0d want %0d", squash_count_o, exp_sq); end
    send(32'h028210FF); exp_dec++;
    nvec++; if (d_exec_o !== 1'b1) begin nfail++; $display("FAIL addeq_exec got %0h want 1", d_exec_o); end
    send(32'h128210FF); exp_dec++; exp_sq++;
    nvec++; if (d_exec_o !== 1'b0) begin nfail++; $display("FAIL addne_exec got %0h want 0", d_exec_o); end
    send(32'hF28210FF); exp_dec++; exp_sq++;
    nvec++; if (d_exec_o !== 1'b0) begin nfail++; $display("FAIL nv_exec got %0h want 0", d_exec_o); end
    nvec++; if (squash_count_o !== 16'(exp_sq)) begin nfail++; $display("FAIL cond_sq got %0d want %0d", squash_count_o, exp_sq); end
  endtask

  task automatic test_forward();
    fwd_valid_i = 2'b11; fwd_dest_i = 8'h33;
    fwd_data_i = {32'h0000BBBB, 32'h0000AAAA};
    send(32'hE0830104); exp_dec++;
    nvec++; if (d_a_o !== 32'hAAAA) begin nfail++; $display("FAIL fwd_prio_a got %0h want aaaa", d_a_o); end
    nvec++; if (d_b_o !== 32'h10000004) begin nfail++; $display("FAIL fwd_b got %0h want 10000004", d_b_o); end
    nvec++; if (d_shift_o !== 8'h10) begin nfail++; $display("FAIL fwd_shift got %0h want 10", d_shift_o); end
    fwd_valid_i = 2'b10;
    send(32'hE0830104); exp_dec++;
    nvec++; if (d_a_o !== 32'hBBBB) begin nfail++; $display("FAIL fwd1_a got %0h want bbbb", d_a_o); end
    fwd_valid_i = 2'b00;
    send(32'hE0830104); exp_dec++;
    nvec++; if (d_a_o !== 32'h10000003) begin nfail++; $display("FAIL fwd_none_a got %0h want 10000003", d_a_o); end
  endtask

  task automatic test_rotate();
    send(32'hE3A00401); exp_dec++;
    nvec++; if (d_b_o !== 32'h01000000) begin nfail++; $display("FAIL rot_b got %0h want 01000000", d_b_o); end
    nvec++; if (d_opcode_o !== 4'hD) begin nfail++; $display("FAIL rot_opcode got %0h want d", d_opcode_o); end
    nvec++; if (d_shift_o !== 8'h00) begin nfail++; $display("FAIL rot_shift got %0h want 0", d_shift_o); end
  endtask

  task automatic test_branch_ls();
    send(32'hEAFFFFFE); exp_dec++;
    nvec++; if (d_class_o !== 4'd1) begin nfail++; $display("FAIL br_class got %0h want 1", d_class_o); end
    nvec++; if (d_b_o !== 32'hFFFFFFF8) begin nfail++; $display("FAIL br_b got %0h want fffffff8", d_b_o); end
    nvec++; if (d_write_dest_o !== 1'b0) begin nfail++; $display("FAIL br_wr got %0h want 0", d_write_dest_o); end
    send(32'hE5921004); exp_dec++;
    nvec++; if (d_class_o !== 4'd4) begin nfail++; $display("FAIL ldr_class got %0h want 4", d_class_o); end
    nvec++; if (d_a_o !== 32'd5 || d_b_o !== 32'd4) begin nfail++; $display("FAIL ldr_ab got %0h/%0h want 5/4", d_a_o, d_b_o); end
    nvec++; if (d_write_dest_o !== 1'b1 || d_dest_o !== 4'd1) begin nfail++; $display("FAIL ldr_dest got %0h/%0h want 1/1", d_write_dest_o, d_dest_o); end
    send(32'hE5821004); exp_dec++;
    nvec++; if (d_class_o !== 4'd5) begin nfail++; $display("FAIL str_class got %0h want 5", d_class_o); end
    nvec++; if (d_d_o !== 32'h10000001) begin nfail++; $display("FAIL str_d got %0h want 10000001", d_d_o); end
    nvec++; if (d_write_dest_o !== 1'b0) begin nfail++; $display("FAIL str_wr got %0h want 0", d_write_dest_o); end
    send(32'hE1A00000); exp_dec++; exp_sq++;
    nvec++; if ({d_class_o, d_exec_o, d_write_dest_o} !== 6'd0) begin nfail++; $display("FAIL nop got %0h/%0h/%0h want 0/0/0", d_class_o, d_exec_o, d_write_dest_o); end
  endtask

  task automatic test_mul();
    send(32'hE0040695); exp_dec++;
`ifdef DECODE_MUL_EN
    nvec++; if (d_class_o !== 4'd3) begin nfail++; $display("FAIL mul_class got %0h want 3", d_class_o); end
    nvec++; if (d_dest_o !== 4'd4) begin nfail++; $display("FAIL mul_dest got %0h want 4", d_dest_o); end
    nvec++; if (d_a_o !== 32'h10000005 || d_b_o !== 32'h10000006) begin nfail++; $display("FAIL mul_ab got %0h/%0h want 10000005/10000006", d_a_o, d_b_o); end
    nvec++; if (d_exec_o !== 1'b1) begin nfail++; $display("FAIL mul_exec got %0h want 1", d_exec_o); end
`else
    exp_sq++;
    nvec++; if (d_class_o !== 4'd0) begin nfail++; $display("FAIL mul_off_class got %0h want 0", d_class_o); end
    nvec++; if (d_exec_o !== 1'b0 || d_write_dest_o !== 1'b0) begin nfail++; $display("FAIL mul_off_exec got %0h/%0h want 0/0", d_exec_o, d_write_dest_o); end
    nvec++; if (d_c_o !== 32'd0 || d_dest_hi_o !== 4'd0) begin nfail++; $display("FAIL mul_off_tie got %0h/%0h want 0/0", d_c_o, d_dest_hi_o); end
`endif
    nvec++; if (squash_count_o !== 16'(exp_sq)) begin nfail++; $display("FAIL mul_sq got %0d want %0d", squash_count_o, exp_sq); end
  endtask

  task automatic test_stall_flush();
    send(32'hE28210FF); exp_dec++;
    d_ready_i = 1'b0;
    instr_i = 32'hE3A00401; instr_valid_i = 1'b1;
    fwd_valid_i = 2'b01; fwd_dest_i = 8'h02; fwd_data_i = {32'd0, 32'h0000DEAD};
    #1;
    nvec++; if (instr_ready_o !== 1'b0) begin nfail++; $display("FAIL stall_ready got %0h want 0", instr_ready_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (d_valid_o !== 1'b1 || d_a_o !== 32'd5 || d_b_o !== 32'hFF || d_opcode_o !== 4'd4)
        begin nfail++; $display("FAIL stall_hold%0d got v%0h a%0h b%0h op%0h want v1 a5 bff op4", i, d_valid_o, d_a_o, d_b_o, d_opcode_o); end
    end
    nvec++; if (dec_count_o !== 16'(exp_dec)) begin nfail++; $display("FAIL stall_dec got %0d want %0d", dec_count_o, exp_dec); end
    fwd_valid_i = 2'b00;
    d_ready_i = 1'b1;
    #1;
    nvec++; if (instr_ready_o !== 1'b1) begin nfail++; $display("FAIL release_ready got %0h want 1", instr_ready_o); end
    tick(); exp_dec++;
    instr_valid_i = 1'b0;
    nvec++; if (d_b_o !== 32'h01000000 || d_opcode_o !== 4'hD) begin nfail++; $display("FAIL release_pkt got %0h/%0h want 01000000/d", d_b_o, d_opcode_o); end
    tick();
    nvec++; if (d_valid_o !== 1'b0) begin nfail++; $display("FAIL drain_valid got %0h want 0", d_valid_o); end
    send(32'hE28210FF); exp_dec++;
    d_ready_i = 1'b0;
    instr_i = 32'hE3A00401; instr_valid_i = 1'b1; flush_i = 1'b1;
    tick(); exp_sq++;
    flush_i = 1'b0; instr_valid_i = 1'b0; d_ready_i = 1'b1;
    nvec++; if (d_valid_o !== 1'b0) begin nfail++; $display("FAIL flush_valid got %0h want 0", d_valid_o); end
    nvec++; if (dec_count_o !== 16'(exp_dec)) begin nfail++; $display("FAIL flush_dec got %0d want %0d", dec_count_o, exp_dec); end
    nvec++; if (squash_count_o !== 16'(exp_sq)) begin nfail++; $display("FAIL flush_sq got %0d want %0d", squash_count_o, exp_sq); end
    tick();
    nvec++; if (d_valid_o !== 1'b0) begin nfail++; $display("FAIL flush_drop got %0h want 0", d_valid_o); end
  endtask

  task automatic test_reset_mid();
    send(32'hE28210FF);
    nvec++; if (d_valid_o !== 1'b1) begin nfail++; $display("FAIL mid_valid_pre got %0h want 1", d_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (d_valid_o !== 1'b0 || d_class_o !== 4'd0 || d_a_o !== 32'd0) begin nfail++; $display("FAIL mid_pkt got %0h/%0h/%0h want 0/0/0", d_valid_o, d_class_o, d_a_o); end
    nvec++; if (dec_count_o !== 16'd0 || squash_count_o !== 16'd0) begin nfail++; $display("FAIL mid_cnt got %0d/%0d want 0/0", dec_count_o, squash_count_o); end
    nvec++; if (instr_ready_o !== 1'b1) begin nfail++; $display("FAIL mid_ready got %0h want 1", instr_ready_o); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h10000000 + i;
    rf[2] = 32'd5;
    test_reset();
    test_add();
    test_cond();
    test_forward();
    test_rotate();
    test_branch_ls();
    test_mul();
    test_stall_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
